// File: rtl/simple_dual_port_ram.sv
// Simple dual-port RAM: one write port with byte enables, one read port (1 or 2 cycle latency),
// and a sweep controller that fills every word with INIT_VALUE after reset or on request.
module simple_dual_port_ram #(
    parameter int                   MEM_DEPTH    = 256,
    parameter int                   MEM_WIDTH    = 32,
    parameter int                   READ_LATENCY = 1,
    parameter int                   RDW_MODE     = 0,
    parameter logic [MEM_WIDTH-1:0] INIT_VALUE   = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear,
    output logic                           busy,
    input  logic                           wr_en,
    input  logic [$clog2(MEM_DEPTH)-1:0]   wr_addr,
    input  logic [MEM_WIDTH-1:0]           wr_data,
    input  logic [MEM_WIDTH/8-1:0]         wr_be,
    input  logic                           rd_en,
    input  logic [$clog2(MEM_DEPTH)-1:0]   rd_addr,
    output logic [MEM_WIDTH-1:0]           rd_data,
    output logic                           rd_valid
);
    localparam int ADDR_W    = $clog2(MEM_DEPTH);
    localparam int NUM_BYTES = MEM_WIDTH / 8;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    typedef enum logic {CLEAR, READY} state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   clr_addr_reg, clr_addr_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= CLEAR;
            clr_addr_reg <= '0;
        end else begin
            state_reg    <= state_next;
            clr_addr_reg <= clr_addr_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        clr_addr_next = clr_addr_reg;
        case (state_reg)
            CLEAR: begin
                if (clear) begin
                    clr_addr_next = '0;
                end else if (clr_addr_reg == LAST_ADDR) begin
                    state_next    = READY;
                    clr_addr_next = '0;
                end else begin
                    clr_addr_next = clr_addr_reg + ADDR_W'(1);
                end
            end
            READY: begin
                if (clear) begin
                    state_next    = CLEAR;
                    clr_addr_next = '0;
                end
            end
            default: begin
                state_next    = CLEAR;
                clr_addr_next = '0;
            end
        endcase
    end

    assign busy = (state_reg == CLEAR);

    logic wr_acc, rd_acc;
    assign wr_acc = wr_en & ~busy;
    assign rd_acc = rd_en & ~busy;

    // The sweep borrows the write port; user writes only reach it in READY.
    logic                   mem_we;
    logic [ADDR_W-1:0]      mem_addr;
    logic [MEM_WIDTH-1:0]   mem_din;
    logic [NUM_BYTES-1:0]   mem_be;

    assign mem_we   = reset & (busy | wr_acc);
    assign mem_addr = busy ? clr_addr_reg : wr_addr;
    assign mem_din  = busy ? INIT_VALUE : wr_data;
    assign mem_be   = busy ? '1 : wr_be;

    logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];
    logic [MEM_WIDTH-1:0] ram_q_reg;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (mem_we && mem_be[i]) begin
                mem[mem_addr][8*i +: 8] <= mem_din[8*i +: 8];
            end
        end
        if (rd_acc) begin
            ram_q_reg <= mem[rd_addr];
        end
    end

    // Same-address write info is captured beside the raw read so new-data mode can merge lanes.
    logic                   v1_reg;
    logic                   byp_hit_reg;
    logic [NUM_BYTES-1:0]   byp_be_reg;
    logic [MEM_WIDTH-1:0]   byp_data_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1_reg       <= 1'b0;
            byp_hit_reg  <= 1'b0;
            byp_be_reg   <= '0;
            byp_data_reg <= '0;
        end else begin
            v1_reg <= rd_acc;
            if (rd_acc) begin
                byp_hit_reg  <= wr_acc && (wr_addr == rd_addr);
                byp_be_reg   <= wr_be;
                byp_data_reg <= wr_data;
            end
        end
    end

    logic                 rdw_new;
    logic [MEM_WIDTH-1:0] word1;

    assign rdw_new = byp_hit_reg && (RDW_MODE != 0);

    for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
        assign word1[8*gi +: 8] = (rdw_new && byp_be_reg[gi]) ? byp_data_reg[8*gi +: 8]
                                                               : ram_q_reg[8*gi +: 8];
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                 v2_reg;
        logic [MEM_WIDTH-1:0] q2_reg;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                v2_reg <= 1'b0;
                q2_reg <= '0;
            end else begin
                v2_reg <= v1_reg;
                if (v1_reg) begin
                    q2_reg <= word1;
                end
            end
        end

        assign rd_data  = q2_reg;
        assign rd_valid = v2_reg;
    end else begin : g_lat1
        // Masks the unreset read register until the first read after reset lands.
        logic shown_reg;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                shown_reg <= 1'b0;
            end else if (rd_acc) begin
                shown_reg <= 1'b1;
            end
        end

        assign rd_data  = shown_reg ? word1 : '0;
        assign rd_valid = v1_reg;
    end
endmodule

// File: doc/simple_dual_port_ram.md
SIMPLE_DUAL_PORT_RAM -- requirements
Module: simple_dual_port_ram

Interface
REQ-001 The block SHALL have parameter MEM_DEPTH, default 256, meaning number of words (power of 2, >=2).
REQ-002 The block SHALL have parameter MEM_WIDTH, default 32, meaning word width in bits (multiple of 8).
REQ-003 The block SHALL have parameter READ_LATENCY, default 1, meaning cycles from accepted rd_en to rd_valid (legal values 1 or 2).
REQ-004 The block SHALL have parameter RDW_MODE, default 0, meaning same-address read-during-write result (0 = old data, 1 = new data).
REQ-005 The block SHALL have parameter INIT_VALUE, default 0, meaning word written to every address by the clear sweep.
REQ-006 The block SHALL have port clk  input  1  meaning single rising-edge clock for all logic.
REQ-007 The block SHALL have port reset  input  1  meaning asynchronous, active-low reset.
REQ-008 The block SHALL have port clear  input  1  meaning single-cycle request to re-initialise the whole memory.
REQ-009 The block SHALL have port busy  output  1  meaning clear sweep in progress; both ports are ignored while high.
REQ-010 The block SHALL have port wr_en  input  1  meaning write request.
REQ-011 The block SHALL have port wr_addr  input  $clog2(MEM_DEPTH)  meaning write address.
REQ-012 The block SHALL have port wr_data  input  MEM_WIDTH  meaning write data.
REQ-013 The block SHALL have port wr_be  input  MEM_WIDTH/8  meaning per-byte write enable, bit i controlling bits [8i+7:8i].
REQ-014 The block SHALL have port rd_en  input  1  meaning read request.
REQ-015 The block SHALL have port rd_addr  input  $clog2(MEM_DEPTH)  meaning read address.
REQ-016 The block SHALL have port rd_data  output  MEM_WIDTH  meaning read data.
REQ-017 The block SHALL have port rd_valid  output  1  meaning rd_data carries the result of an accepted read this cycle.

Function
REQ-018 The controller SHALL have two states: CLEAR (busy=1) and READY (busy=0).
REQ-019 In CLEAR, the controller SHALL write INIT_VALUE to address clr_addr each cycle and increment clr_addr, with clr_addr starting at 0.
REQ-020 The cycle that writes address MEM_DEPTH-1 SHALL be the last CLEAR cycle; busy SHALL be 0 on the following cycle, with a sweep duration of exactly MEM_DEPTH cycles.
REQ-021 clear=1 sampled in READY SHALL enter CLEAR next cycle with clr_addr=0; clear=1 sampled in CLEAR SHALL restart the sweep at address 0.
REQ-022 A write SHALL be accepted when wr_en=1 and busy=0, updating only the byte lanes whose wr_be bit is 1 at the next clock edge; wr_be=0 SHALL leave memory unchanged.
REQ-023 A read SHALL be accepted when rd_en=1 and busy=0; its data SHALL appear on rd_data with rd_valid=1 exactly READ_LATENCY cycles later.
REQ-024 With READ_LATENCY=2, an additional output register stage SHALL be used; back-to-back reads SHALL sustain one result per cycle.
REQ-025 rd_valid SHALL be 0 in every cycle without a matured accepted read; rd_data SHALL hold its last value when rd_valid=0.
REQ-026 When an accepted read and an accepted write target the same address in the same cycle, RDW_MODE=0 SHALL return the pre-write word, and RDW_MODE=1 SHALL return the post-write word with byte-enable merging applied.
REQ-027 Reads accepted before clear is asserted SHALL still complete with rd_valid; reads and writes presented while busy=1 SHALL be dropped with no effect.
REQ-028 clear, wr_en and rd_en sampled in the same READY cycle: the write and read SHALL be performed, then the sweep SHALL start next cycle.

Reset
REQ-029 While reset=0, the block SHALL force busy=1, rd_valid=0, rd_data=0, clr_addr=0, clear all read pipeline valids, and set the state to CLEAR; memory contents are not reset directly.
REQ-030 After reset deasserts, the block SHALL perform a full sweep; reset asserted mid-sweep or mid-read SHALL abort the operation and restart the sweep from address 0 after release.

Verification
REQ-031 Release reset with MEM_DEPTH=256 -> busy high exactly 256 cycles; reading addresses 0, 17 and 255 -> 0 with rd_valid=1 one cycle later.
REQ-032 Write 0xAABBCCDD to address 5 with wr_be=4'b1111, then write 0x11223344 to address 5 with wr_be=4'b0101; read address 5 -> 0xAA22CC44.
REQ-033 Address 9 holds 0x0; same cycle: write 0xDEADBEEF with wr_be=4'b1111 and read address 9 -> RDW_MODE=0 returns 0x00000000, RDW_MODE=1 returns 0xDEADBEEF.
REQ-034 READ_LATENCY=2, reads to addresses 1,2,3 on consecutive cycles -> rd_valid high on cycles +2,+3,+4 carrying the data for addresses 1,2,3 in order.
REQ-035 Pulse clear at sweep address 100 -> sweep restarts at address 0 and busy lasts 256 more cycles; wr_en during busy -> memory is unchanged afterward.
REQ-036 Assert reset for 1 cycle mid-sweep while a read is pending -> rd_valid never rises for that read; the sweep restarts at address 0.
